apb_cfg_sequencer: RTL

APB_CFG_SEQUENCER -- requirements
Module: apb_cfg_sequencer

---
 rtl/apb_cfg_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_cfg_sequencer.sv
// Command-driven APB master: WRITE, READ and masked POLL of one register per command.
// Define APB_SEQ_POLL_TIMEOUT_EN to bound each POLL to POLL_MAX reads (error response on expiry).
module apb_cfg_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int POLL_MAX = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mask_q, mask_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_SEQ_POLL_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_MAX + 1);
    logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
`endif

    logic              poll_match;

    assign poll_match = ((PRDATA & mask_q) == (data_q & mask_q));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_SEQ_POLL_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    mask_d      = cmd_mask;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
`ifdef APB_SEQ_POLL_TIMEOUT_EN
                    poll_cnt_d  = '0;
`endif
                    if (cmd_op == 2'b11) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = S_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = cmd_addr;
                        pwrite_d  = (cmd_op == OP_WRITE);
                        pwdata_d  = (cmd_op == OP_WRITE) ? cmd_data : '0;
                    end
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end

            S_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    if (op_q == OP_WRITE) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                    end else if (op_q == OP_READ || (op_q == OP_POLL && poll_match)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = PRDATA;
                        rsp_err_d   = 1'b0;
                    end else begin
`ifdef APB_SEQ_POLL_TIMEOUT_EN
                        // The counter holds reads already completed, so this is the last allowed one.
                        if (poll_cnt_q == CNT_W'(POLL_MAX - 1)) begin
                            state_d     = S_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = PRDATA;
                            rsp_err_d   = 1'b1;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 1'b1;
                            state_d    = S_GAP;
                        end
`else
                        state_d = S_GAP;
`endif
                    end
                end
            end

            S_GAP: begin
                state_d   = S_SETUP;
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = addr_q;
                pwrite_d  = 1'b0;
                pwdata_d  = '0;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                pwrite_d    = 1'b0;
                paddr_d     = '0;
                pwdata_d    = '0;
                rsp_valid_d = 1'b0;
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_SEQ_POLL_TIMEOUT_EN
            poll_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_SEQ_POLL_TIMEOUT_EN
            poll_cnt_q  <= poll_cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule
